float_accumulator: RTL and testbench

- Sequential floating-point accumulator placed directly downstream of the combinational float multiplier.
- Consumes a stream of IEEE-754-style products over a val/rdy interface and sums them into a running total.
- Emits the total when the input word tagged `last` has been added.
- Each addition uses a multi-cycle align / add / normalize FSM, giving a compact datapath for MAC-style chains such as FIR and FFT magnitude.

---
 rtl/float_pkg.sv | 28 ++
 rtl/float_accumulator_if.sv | 24 ++
 rtl/float_unpack.sv | 30 +++
 rtl/float_accumulator.sv | 209 ++++++++++++++++++++
 tb/tb_float_accumulator.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/float_pkg.sv
// Shared constants, state encoding and helpers for the float accumulator.
package float_pkg;

    localparam int DEF_BIT_WIDTH = 32;
    localparam int DEF_M_WIDTH   = 23;
    localparam int DEF_E_WIDTH   = 8;
    localparam int GUARD_BITS    = 3;

    // Canonical special values for the default 32-bit format.
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF   = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF   = 32'hFF80_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        CHECK,
        DONE
    } state_t;

    // Exponent bias for a given exponent width.
    function automatic int bias(input int e_width);
        return (1 << (e_width - 1)) - 1;
    endfunction

endpackage

// File: rtl/float_accumulator_if.sv
// Input operand stream and output sum stream of the accumulator.
interface float_accumulator_if
    import float_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH
);
    logic                 recv_val;
    logic                 recv_rdy;
    logic [BIT_WIDTH-1:0] recv_msg;
    logic                 recv_last;
    logic                 send_val;
    logic                 send_rdy;
    logic [BIT_WIDTH-1:0] send_msg;

    modport master (
        output recv_val, recv_msg, recv_last, send_rdy,
        input  recv_rdy, send_val, send_msg
    );

    modport slave (
        input  recv_val, recv_msg, recv_last, send_rdy,
        output recv_rdy, send_val, send_msg
    );
endinterface

// File: rtl/float_unpack.sv
// Splits a packed float into sign, exponent and a working mantissa
// (hidden bit + stored bits + guard zeros) and classifies it.
module float_unpack
    import float_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int M_WIDTH   = DEF_M_WIDTH,
    parameter int E_WIDTH   = DEF_E_WIDTH
) (
    input  logic [BIT_WIDTH-1:0]             word,
    output logic                             sign,
    output logic [E_WIDTH-1:0]               exp,
    output logic [M_WIDTH+GUARD_BITS:0]      man,
    output logic                             is_zero,
    output logic                             is_inf,
    output logic                             is_nan
);
    logic [M_WIDTH-1:0] frac;

    // Field extraction; exponent 0 flushes the value (and any subnormal) to zero.
    always_comb begin
        sign    = word[BIT_WIDTH-1];
        exp     = word[BIT_WIDTH-2 -: E_WIDTH];
        frac    = word[M_WIDTH-1:0];
        is_zero = (exp == '0);
        is_inf  = (exp == '1) && (frac == '0);
        is_nan  = (exp == '1) && (frac != '0);
        man     = is_zero ? '0 : {1'b1, frac, {GUARD_BITS{1'b0}}};
    end
endmodule

// File: rtl/float_accumulator.sv
// Multi-cycle floating-point accumulator: align / add / normalize per term,
// emits the running total after the term tagged last.
module float_accumulator
    import float_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int M_WIDTH   = DEF_M_WIDTH,
    parameter int E_WIDTH   = DEF_E_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    float_accumulator_if.slave bus
);
    localparam int MAN_W     = 1 + M_WIDTH + GUARD_BITS;
    localparam int SUM_W     = MAN_W + 1;
    localparam int ALIGN_MAX = M_WIDTH + GUARD_BITS;
    localparam int CNT_W     = $clog2(ALIGN_MAX + 2);
    localparam logic [E_WIDTH-1:0]   EXP_MAX  = '1;
    localparam logic [E_WIDTH-1:0]   EXP_TOP  = EXP_MAX - 1'b1;
    localparam logic [BIT_WIDTH-1:0] NAN_WORD = {1'b0, {E_WIDTH{1'b1}}, 1'b1, {(M_WIDTH-1){1'b0}}};

    state_t                 state_reg, state_next;
    logic [BIT_WIDTH-1:0]   acc_reg, acc_next;
    logic [BIT_WIDTH-1:0]   send_msg_reg, send_msg_next;
    logic                   last_reg, last_next;
    logic                   a_sign_reg, a_sign_next, b_sign_reg, b_sign_next;
    logic [E_WIDTH-1:0]     a_exp_reg, a_exp_next, b_exp_reg, b_exp_next;
    logic [MAN_W-1:0]       a_man_reg, a_man_next, b_man_reg, b_man_next;
    logic [SUM_W-1:0]       sum_reg, sum_next;
    logic                   res_sign_reg, res_sign_next;
    logic [E_WIDTH-1:0]     res_exp_reg, res_exp_next;
    logic [CNT_W-1:0]       align_cnt_reg, align_cnt_next;

    logic                   acc_sign, op_sign;
    logic [E_WIDTH-1:0]     acc_exp, op_exp;
    logic [MAN_W-1:0]       acc_man, op_man;
    logic                   acc_zero, acc_inf, acc_nan;
    logic                   op_zero, op_inf, op_nan;
    logic                   unused_zero_flags;

    logic                   xfer;
    logic                   a_small;
    logic [E_WIDTH-1:0]     exp_diff;
    logic                   align_last;

    float_unpack #(.BIT_WIDTH(BIT_WIDTH), .M_WIDTH(M_WIDTH), .E_WIDTH(E_WIDTH)) u_unpack_acc (
        .word(acc_reg), .sign(acc_sign), .exp(acc_exp), .man(acc_man),
        .is_zero(acc_zero), .is_inf(acc_inf), .is_nan(acc_nan)
    );

    float_unpack #(.BIT_WIDTH(BIT_WIDTH), .M_WIDTH(M_WIDTH), .E_WIDTH(E_WIDTH)) u_unpack_op (
        .word(bus.recv_msg), .sign(op_sign), .exp(op_exp), .man(op_man),
        .is_zero(op_zero), .is_inf(op_inf), .is_nan(op_nan)
    );

    // Zero operands need no special path: a zero mantissa aligns and adds naturally.
    assign unused_zero_flags = acc_zero ^ op_zero;

    assign bus.recv_rdy = (state_reg == IDLE) && reset;
    assign bus.send_val = (state_reg == DONE);
    assign bus.send_msg = send_msg_reg;
    assign xfer         = bus.recv_val && bus.recv_rdy;

    // State and datapath registers; reset abandons any group in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            send_msg_reg  <= '0;
            last_reg      <= 1'b0;
            a_sign_reg    <= 1'b0;
            b_sign_reg    <= 1'b0;
            a_exp_reg     <= '0;
            b_exp_reg     <= '0;
            a_man_reg     <= '0;
            b_man_reg     <= '0;
            sum_reg       <= '0;
            res_sign_reg  <= 1'b0;
            res_exp_reg   <= '0;
            align_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            send_msg_reg  <= send_msg_next;
            last_reg      <= last_next;
            a_sign_reg    <= a_sign_next;
            b_sign_reg    <= b_sign_next;
            a_exp_reg     <= a_exp_next;
            b_exp_reg     <= b_exp_next;
            a_man_reg     <= a_man_next;
            b_man_reg     <= b_man_next;
            sum_reg       <= sum_next;
            res_sign_reg  <= res_sign_next;
            res_exp_reg   <= res_exp_next;
            align_cnt_reg <= align_cnt_next;
        end
    end

    // Next-state and datapath logic for the align / add / normalize sequence.
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        send_msg_next  = send_msg_reg;
        last_next      = last_reg;
        a_sign_next    = a_sign_reg;
        b_sign_next    = b_sign_reg;
        a_exp_next     = a_exp_reg;
        b_exp_next     = b_exp_reg;
        a_man_next     = a_man_reg;
        b_man_next     = b_man_reg;
        sum_next       = sum_reg;
        res_sign_next  = res_sign_reg;
        res_exp_next   = res_exp_reg;
        align_cnt_next = align_cnt_reg;

        a_small    = (a_exp_reg < b_exp_reg);
        exp_diff   = a_small ? (b_exp_reg - a_exp_reg) : (a_exp_reg - b_exp_reg);
        // Final align step: exponents one apart, or the shift budget is spent.
        align_last = (exp_diff == E_WIDTH'(1)) || (align_cnt_reg == CNT_W'(ALIGN_MAX));

        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    last_next      = bus.recv_last;
                    a_sign_next    = acc_sign;
                    a_exp_next     = acc_exp;
                    a_man_next     = acc_man;
                    b_sign_next    = op_sign;
                    b_exp_next     = op_exp;
                    b_man_next     = op_man;
                    align_cnt_next = '0;
                    if (acc_nan || op_nan || acc_inf || op_inf) begin
                        if (acc_nan || op_nan || (acc_inf && op_inf && (acc_sign != op_sign)))
                            acc_next = NAN_WORD;
                        else if (!acc_inf)
                            acc_next = {op_sign, EXP_MAX, {M_WIDTH{1'b0}}};
                        state_next = CHECK;
                    end else if (acc_exp == op_exp) begin
                        state_next = ADD;
                    end else begin
                        state_next = ALIGN;
                    end
                end
            end
            ALIGN: begin
                align_cnt_next = align_cnt_reg + 1'b1;
                if (a_small) begin
                    a_man_next = (exp_diff > E_WIDTH'(ALIGN_MAX)) ? '0 : (a_man_reg >> 1);
                    a_exp_next = align_last ? b_exp_reg : (a_exp_reg + 1'b1);
                end else begin
                    b_man_next = (exp_diff > E_WIDTH'(ALIGN_MAX)) ? '0 : (b_man_reg >> 1);
                    b_exp_next = align_last ? a_exp_reg : (b_exp_reg + 1'b1);
                end
                if (align_last)
                    state_next = ADD;
            end
            ADD: begin
                res_exp_next = a_exp_reg;
                if (a_sign_reg == b_sign_reg) begin
                    sum_next      = {1'b0, a_man_reg} + {1'b0, b_man_reg};
                    res_sign_next = a_sign_reg;
                end else if (a_man_reg >= b_man_reg) begin
                    sum_next      = {1'b0, a_man_reg} - {1'b0, b_man_reg};
                    res_sign_next = a_sign_reg;
                end else begin
                    sum_next      = {1'b0, b_man_reg} - {1'b0, a_man_reg};
                    res_sign_next = b_sign_reg;
                end
                state_next = NORM;
            end
            NORM: begin
                if (sum_reg == '0) begin
                    acc_next   = '0;
                    state_next = CHECK;
                end else if (sum_reg[SUM_W-1]) begin
                    if (res_exp_reg == EXP_TOP)
                        acc_next = {res_sign_reg, EXP_MAX, {M_WIDTH{1'b0}}};
                    else
                        acc_next = {res_sign_reg, res_exp_reg + 1'b1, sum_reg[SUM_W-2 -: M_WIDTH]};
                    state_next = CHECK;
                end else if (sum_reg[MAN_W-1]) begin
                    acc_next   = {res_sign_reg, res_exp_reg, sum_reg[MAN_W-2 -: M_WIDTH]};
                    state_next = CHECK;
                end else if (res_exp_reg == E_WIDTH'(1)) begin
                    acc_next   = '0;
                    state_next = CHECK;
                end else begin
                    sum_next     = sum_reg << 1;
                    res_exp_next = res_exp_reg - 1'b1;
                end
            end
            CHECK: begin
                if (last_reg) begin
                    send_msg_next = acc_reg;
                    state_next    = DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                if (bus.send_rdy) begin
                    acc_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_float_accumulator.sv
// Self-checking bench for float_accumulator: directed groups plus random
// groups compared against an arithmetic reference model.
module tb_float_accumulator;
    import float_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    float_accumulator_if #(.BIT_WIDTH(32)) bus ();

    float_accumulator #(.BIT_WIDTH(32), .M_WIDTH(23), .E_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        n_checks++;
        if (got !== expected) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, expected);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Reference: one accumulation step, computed from the number-format rules
    // (3 guard bits, truncating alignment, truncating result, flush to zero).
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e, d;
        bit     a_nan, b_nan, a_inf, b_inf, sg;
        longint ma, mb, s, mag;
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        a_nan = (ea == 255) && (a[22:0] != 0);
        b_nan = (eb == 255) && (b[22:0] != 0);
        a_inf = (ea == 255) && (a[22:0] == 0);
        b_inf = (eb == 255) && (b[22:0] == 0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
            return CANON_NAN;
        if (a_inf) return a;
        if (b_inf) return b;
        ma = (ea == 0) ? 0 : (longint'({1'b1, a[22:0]}) << 3);
        mb = (eb == 0) ? 0 : (longint'({1'b1, b[22:0]}) << 3);
        e  = (ea > eb) ? ea : eb;
        d  = ea - eb;
        if (d > 0)      mb = (d > 26)  ? 0 : (mb >> d);
        else if (d < 0) ma = (-d > 26) ? 0 : (ma >> (-d));
        s = (a[31] ? -ma : ma) + (b[31] ? -mb : mb);
        if (s == 0) return 32'h0;
        sg  = (s < 0);
        mag = sg ? -s : s;
        if (mag >= (longint'(1) << 27)) begin
            mag = mag >> 1;
            e   = e + 1;
            if (e >= 255) return {sg, 8'hFF, 23'h0};
        end else begin
            while (mag < (longint'(1) << 26)) begin
                mag = mag << 1;
                e   = e - 1;
                if (e == 0) return 32'h0;
            end
        end
        return {sg, 8'(e), 23'(mag >> 3)};
    endfunction

    task automatic push(input logic [31:0] w, input logic last);
        int waited = 0;
        @(negedge clk);
        bus.recv_val  = 1'b1;
        bus.recv_msg  = w;
        bus.recv_last = last;
        while (!bus.recv_rdy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.recv_rdy)
            check("recv_rdy timeout", 32'(bus.recv_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.recv_val  = 1'b0;
        bus.recv_last = 1'b0;
    endtask

    task automatic wait_send_val();
        int waited = 0;
        @(negedge clk);
        while (!bus.send_val && waited < 300) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic collect(input string tag, input logic [31:0] expected);
        wait_send_val();
        check({tag, " send_val"}, 32'(bus.send_val), 32'd1);
        check(tag, bus.send_msg, expected);
        bus.send_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.send_rdy = 1'b0;
        @(negedge clk);
        check({tag, " once"}, 32'(bus.send_val), 32'd0);
    endtask

    task automatic run_group(input string tag, input logic [31:0] w[$], input logic [31:0] expected);
        for (int i = 0; i < w.size(); i++)
            push(w[i], (i == w.size() - 1));
        collect(tag, expected);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) return 32'h0;
        return {r[31], 8'($urandom_range(110, 140)), r[22:0]};
    endfunction

    initial begin
        logic [31:0] q[$];
        logic [31:0] acc_m;
        logic [31:0] w;
        int          n;

        bus.recv_val  = 1'b0;
        bus.recv_msg  = '0;
        bus.recv_last = 1'b0;
        bus.send_rdy  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset recv_rdy", 32'(bus.recv_rdy), 32'd0);
        check("reset send_val", 32'(bus.send_val), 32'd0);
        check("reset send_msg", bus.send_msg, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("idle recv_rdy", 32'(bus.recv_rdy), 32'd1);

        // Directed groups
        q = '{32'h3F800000, 32'h40000000};
        run_group("1+2", q, 32'h40400000);
        q = '{32'h3FC00000, 32'h40200000, 32'hBF800000};
        run_group("1.5+2.5-1", q, 32'h40400000);
        q = '{32'h3F800000, 32'hBF800000};
        run_group("cancel", q, 32'h00000000);
        q = '{32'h4B800000, 32'h3F800000};
        run_group("shift out", q, 32'h4B800000);
        q = '{32'h7F800000, 32'hFF800000};
        run_group("inf-inf", q, 32'h7FC00000);
        q = '{32'h7F7FFFFF, 32'h7F7FFFFF};
        run_group("overflow", q, 32'h7F800000);
        q = '{32'h7FC00001, 32'h3F800000};
        run_group("nan sticky", q, 32'h7FC00000);
        q = '{32'hFF800000, 32'h3F800000};
        run_group("inf+fin", q, 32'hFF800000);
        q = '{32'h40400000, 32'h00000000};
        run_group("zero last", q, 32'h40400000);

        // Backpressure on the result
        push(32'h40400000, 1'b1);
        wait_send_val();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d send_val", i), 32'(bus.send_val), 32'd1);
            check($sformatf("bp%0d send_msg", i), bus.send_msg, 32'h40400000);
            check($sformatf("bp%0d recv_rdy", i), 32'(bus.recv_rdy), 32'd0);
            @(negedge clk);
        end
        collect("bp release", 32'h40400000);
        q = '{32'h3F800000};
        run_group("after bp", q, 32'h3F800000);

        // Reset while aligning
        push(32'h3F800000, 1'b0);
        push(32'h45000000, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst send_val", 32'(bus.send_val), 32'd0);
        check("midrst recv_rdy", 32'(bus.recv_rdy), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst idle", 32'(bus.recv_rdy), 32'd1);
        q = '{32'h40000000};
        run_group("after rst", q, 32'h40000000);

        // Random groups against the reference model
        for (int g = 0; g < 20; g++) begin
            n = $urandom_range(1, 4);
            q.delete();
            acc_m = 32'h0;
            for (int k = 0; k < n; k++) begin
                w = rand_word();
                q.push_back(w);
                acc_m = model_add(acc_m, w);
            end
            run_group($sformatf("rand%0d", g), q, acc_m);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
